aes_key_schedule: RTL and testbench
===================================

AES_KEY_SCHEDULE -- requirements
Module: aes_key_schedule

Interface
REQ-001 SHALL have parameter KEY_BITS, default 128, giving cipher key width (128/192/256).
REQ-002 SHALL have parameter NR, default 10, giving round count (10/12/14).
REQ-003 SHALL have parameter NK, default 4, giving key length in 32-bit words (4/6/8).
REQ-004 SHALL have port clk, input, 1, the only clock; all state on rising edge.
REQ-005 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-006 SHALL have port key_valid, input, 1, key_in valid.
REQ-007 SHALL have port key_ready, output, 1, block accepts a new key.
REQ-008 SHALL have port key_in, input, [0:KEY_BITS-1], cipher key, bit 0 MSB, word 0 leftmost.
REQ-009 SHALL have port rk_idx, input, 4, round-key select 0..NR.
REQ-010 SHALL have port rk_out, output, [0:127], round key words 4*rk_idx..4*rk_idx+3.
REQ-011 SHALL have port done, output, 1, full schedule stored and readable.

Function
REQ-012 SHALL implement FSM states IDLE, EXPAND, DONE.
REQ-013 SHALL assert key_ready in IDLE and DONE and deassert it in EXPAND.
REQ-014 SHALL accept a key on a rising edge with key_valid and key_ready both high: store w[0..NK-1] from key_in, set word counter i=NK, clear done, enter EXPAND.
REQ-015 SHALL in EXPAND write exactly one word w[i] per cycle, then increment i.
REQ-016 SHALL compute w[i] = w[i-NK] xor temp: temp = SubWord(RotWord(w[i-1])) xor Rcon[i/NK] when i mod NK = 0; SubWord(w[i-1]) when NK = 8 and i mod NK = 4; else w[i-1].
REQ-017 SHALL leave EXPAND for DONE on the cycle w[4*NR+3] is written, asserting done that edge: 40/46/52 cycles after acceptance for NK=4/6/8.
REQ-018 SHALL hold done high in DONE until the next key acceptance.
REQ-019 SHALL ignore key_valid during EXPAND; no restart, no word corruption.
REQ-020 SHALL accept a new key in DONE (re-key) exactly as from IDLE, deasserting done on the accepting edge.
REQ-021 SHALL drive rk_out combinationally from storage for any rk_idx, zero for rk_idx > NR; consumers qualify with done.
REQ-022 SHALL generate Rcon by an 8-bit GF(2^8) xtime register (01,02,...,80,1b,36) reset on acceptance, not a divider.

Reset
REQ-023 SHALL on rst_n low immediately: state IDLE, key_ready 1, done 0, i 0, all stored words 0 (so rk_out = 0).
REQ-024 SHALL abandon an expansion in progress when reset asserts mid-EXPAND; no partial done.

Configuration
REQ-025 SHALL when AES_KS_ZEROIZE_EN is defined add input zeroize (1 bit): high on a clock edge clears all words, done, i, returns to IDLE, taking priority over key acceptance.
REQ-026 SHALL without AES_KS_ZEROIZE_EN have no zeroize port; stored words clear only by reset.

Structure
REQ-027 SHALL take word typedef, S-box table, per-size NK/NR constants and state enum from shared package aes_pkg, also used by Encyrption.
REQ-028 SHALL instantiate sub-module aes_sbox four times for SubWord, identical to the cipher S-box.
REQ-029 SHALL reject unsupported (KEY_BITS, NR, NK) combinations at elaboration.

Verification
REQ-030 SHALL check 128-bit key 2b7e151628aed2a6abf7158809cf4f3c -> done after 40 cycles; rk_idx 1 = a0fafe1788542cb123a339392a6c7605, rk_idx 10 = d014f9a8c9ee2589e13f0cc8b6630ca6.
REQ-031 SHALL check (192,12,6) key 000102...1617 -> done after 46 cycles; rk_idx 12 = a4970a331a78dc09c418c271e3a41d5d.
REQ-032 SHALL check (256,14,8) key 000102...1e1f -> done after 52 cycles; rk_idx 14 = 24fc79ccbf0979e9371ac23c6d68de36.
REQ-033 SHALL pulse key_valid with a different key at cycle 10 of EXPAND -> key_ready 0, ignored, REQ-030 results unchanged.
REQ-034 SHALL assert rst_n low at cycle 20 of EXPAND -> done 0, key_ready 1, rk_out 0 for all rk_idx; re-key then completes correctly.
REQ-035 SHALL with AES_KS_ZEROIZE_EN pulse zeroize in DONE -> next cycle done 0, rk_idx 10 reads 0.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared AES definitions: word type, S-box table, key-size constants and the
// key-schedule state encoding. Also imported by the cipher datapath.
package aes_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        EXPAND = 2'd1,
        DONE   = 2'd2
    } ks_state_e;

    localparam int NK_128 = 4;
    localparam int NR_128 = 10;
    localparam int NK_192 = 6;
    localparam int NR_192 = 12;
    localparam int NK_256 = 8;
    localparam int NR_256 = 14;

    // Byte b of the table sits at bits [8*b +: 8].
    localparam logic [0:2047] SBOX_TABLE = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sbox_lookup(input logic [7:0] b);
        return SBOX_TABLE[{b, 3'b000} +: 8];
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic bit ks_cfg_ok(input int kb, input int nr, input int nk);
        return (kb == 128 && nr == NR_128 && nk == NK_128) ||
               (kb == 192 && nr == NR_192 && nk == NK_192) ||
               (kb == 256 && nr == NR_256 && nk == NK_256);
    endfunction

endpackage

// File: rtl/aes_key_schedule_if.sv
// Key load / round-key read bundle between a key-schedule consumer and the
// aes_key_schedule block.
interface aes_key_schedule_if #(
    parameter int KEY_BITS = 128
);
    logic                  key_valid;
    logic                  key_ready;
    logic [0:KEY_BITS-1]   key_in;
    logic [3:0]            rk_idx;
    logic [0:127]          rk_out;
    logic                  done;

    modport master (
        output key_valid, key_in, rk_idx,
        input  key_ready, rk_out, done
    );

    modport slave (
        input  key_valid, key_in, rk_idx,
        output key_ready, rk_out, done
    );
endinterface

// File: rtl/aes_sbox.sv
// Single-byte AES forward S-box, shared with the cipher SubBytes stage.
module aes_sbox
    import aes_pkg::*;
(
    input  logic [7:0] a,
    output logic [7:0] y
);
    assign y = sbox_lookup(a);
endmodule

// File: rtl/aes_key_schedule.sv
// Iterative AES key expansion: one schedule word per cycle into a register
// file, round keys read combinationally. Optional AES_KS_ZEROIZE_EN adds a
// synchronous zeroize input.
module aes_key_schedule
    import aes_pkg::*;
#(
    parameter int KEY_BITS = 128,
    parameter int NR       = 10,
    parameter int NK       = 4
) (
    input  logic clk,
    input  logic rst_n,
`ifdef AES_KS_ZEROIZE_EN
    input  logic zeroize,
`endif
    aes_key_schedule_if.slave ks
);

    localparam int              NWORDS = 4 * (NR + 1);
    localparam int              IW     = 6;
    localparam logic [IW-1:0]   LAST_W = IW'(NWORDS - 1);
    localparam logic [IW-1:0]   NK_W   = IW'(NK);
    localparam logic [2:0]      NK_M1  = 3'(NK - 1);

    if (!ks_cfg_ok(KEY_BITS, NR, NK) || KEY_BITS != 32 * NK) begin : g_bad_cfg
        $error("aes_key_schedule: unsupported KEY_BITS/NR/NK combination");
    end

    ks_state_e      state_q, state_d;
    word_t          w_q [NWORDS];
    word_t          w_d [NWORDS];
    logic [IW-1:0]  i_q, i_d;
    logic [2:0]     j_q, j_d;       // i mod NK, tracked incrementally
    logic [7:0]     rcon_q, rcon_d;
    logic           done_q, done_d;

    word_t          prev_w, old_w, sub_in, sub_out, temp;
    logic           accept;
    logic [IW-1:0]  rk_base;
    logic [0:127]   rk;

    assign prev_w = w_q[i_q - IW'(1)];
    assign old_w  = w_q[i_q - NK_W];
    assign sub_in = (j_q == 3'd0) ? {prev_w[23:0], prev_w[31:24]} : prev_w;

    for (genvar b = 0; b < 4; b++) begin : g_sbox
        aes_sbox u_sbox (
            .a (sub_in[8*b +: 8]),
            .y (sub_out[8*b +: 8])
        );
    end

    always_comb begin
        temp = prev_w;
        if (j_q == 3'd0) begin
            temp = sub_out ^ {rcon_q, 24'h000000};
        end else if (NK == 8 && j_q == 3'd4) begin
            temp = sub_out;
        end
    end

    assign accept = ks.key_valid && (state_q != EXPAND);

    always_comb begin
        state_d = state_q;
        w_d     = w_q;
        i_d     = i_q;
        j_d     = j_q;
        rcon_d  = rcon_q;
        done_d  = done_q;

        case (state_q)
            IDLE, DONE: begin
                if (accept) begin
                    for (int unsigned k = 0; k < NK; k++) begin
                        w_d[k] = ks.key_in[32*k +: 32];
                    end
                    i_d     = NK_W;
                    j_d     = 3'd0;
                    rcon_d  = 8'h01;
                    done_d  = 1'b0;
                    state_d = EXPAND;
                end
            end
            EXPAND: begin
                w_d[i_q] = old_w ^ temp;
                i_d      = i_q + IW'(1);
                j_d      = (j_q == NK_M1) ? 3'd0 : j_q + 3'd1;
                if (j_q == 3'd0) begin
                    rcon_d = xtime(rcon_q);
                end
                if (i_q == LAST_W) begin
                    done_d  = 1'b1;
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase

`ifdef AES_KS_ZEROIZE_EN
        if (zeroize) begin
            for (int unsigned k = 0; k < NWORDS; k++) begin
                w_d[k] = '0;
            end
            i_d     = '0;
            j_d     = '0;
            rcon_d  = 8'h01;
            done_d  = 1'b0;
            state_d = IDLE;
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            for (int unsigned k = 0; k < NWORDS; k++) begin
                w_q[k] <= '0;
            end
            i_q     <= '0;
            j_q     <= '0;
            rcon_q  <= 8'h01;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            w_q     <= w_d;
            i_q     <= i_d;
            j_q     <= j_d;
            rcon_q  <= rcon_d;
            done_q  <= done_d;
        end
    end

    assign rk_base = {ks.rk_idx, 2'b00};

    always_comb begin
        rk = '0;
        if (ks.rk_idx <= 4'(NR)) begin
            for (int unsigned k = 0; k < 4; k++) begin
                rk[32*k +: 32] = w_q[rk_base + IW'(k)];
            end
        end
    end

    assign ks.rk_out    = rk;
    assign ks.key_ready = (state_q != EXPAND);
    assign ks.done      = done_q;

endmodule

// File: tb/tb_aes_key_schedule.sv
// Directed-vector bench for aes_key_schedule using FIPS-197 expansion examples
// for all three key sizes.
module tb_aes_key_schedule;

    logic clk;
    logic rst_n;
`ifdef AES_KS_ZEROIZE_EN
    logic zeroize;
`endif

    int errors;
    int checks;

    localparam logic [127:0] K128  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] KBAD  = 128'hffeeddccbbaa99887766554433221100;
    localparam logic [191:0] K192  = 192'h000102030405060708090a0b0c0d0e0f1011121314151617;
    localparam logic [255:0] K256  = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;

    aes_key_schedule_if #(.KEY_BITS(128)) if128 ();
    aes_key_schedule_if #(.KEY_BITS(192)) if192 ();
    aes_key_schedule_if #(.KEY_BITS(256)) if256 ();

    aes_key_schedule #(.KEY_BITS(128), .NR(10), .NK(4)) u_ks128 (
        .clk     (clk),
        .rst_n   (rst_n),
`ifdef AES_KS_ZEROIZE_EN
        .zeroize (zeroize),
`endif
        .ks      (if128)
    );

    aes_key_schedule #(.KEY_BITS(192), .NR(12), .NK(6)) u_ks192 (
        .clk     (clk),
        .rst_n   (rst_n),
`ifdef AES_KS_ZEROIZE_EN
        .zeroize (zeroize),
`endif
        .ks      (if192)
    );

    aes_key_schedule #(.KEY_BITS(256), .NR(14), .NK(8)) u_ks256 (
        .clk     (clk),
        .rst_n   (rst_n),
`ifdef AES_KS_ZEROIZE_EN
        .zeroize (zeroize),
`endif
        .ks      (if256)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [2:0] dones;
    assign dones = {if256.done, if192.done, if128.done};

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Counts rising edges after acceptance until done; optionally pulses a
    // foreign key into the 128-bit instance during expansion.
    task automatic wait_done(input int sel, input int pulse_at, output int cyc);
        cyc = 0;
        while (!dones[sel] && cyc < 200) begin
            @(negedge clk);
            if (sel == 0 && cyc == pulse_at) begin
                if128.key_valid = 1'b1;
                if128.key_in    = KBAD;
                check_eq("ready_low_in_expand", 128'(if128.key_ready), 128'd0);
            end else begin
                if128.key_valid = 1'b0;
            end
            @(posedge clk);
            #1;
            cyc++;
        end
        if128.key_valid = 1'b0;
    endtask

    task automatic read128(input int idx, output logic [127:0] v);
        if128.rk_idx = 4'(idx);
        #1;
        v = if128.rk_out;
    endtask

    int           cyc;
    logic [127:0] v;

    initial begin
        errors = 0;
        checks = 0;
        rst_n  = 1'b0;
`ifdef AES_KS_ZEROIZE_EN
        zeroize = 1'b0;
`endif
        if128.key_valid = 1'b0; if128.key_in = '0; if128.rk_idx = 4'd0;
        if192.key_valid = 1'b0; if192.key_in = '0; if192.rk_idx = 4'd0;
        if256.key_valid = 1'b0; if256.key_in = '0; if256.rk_idx = 4'd0;

        #3;
        check_eq("rst_done",   128'(if128.done), 128'd0);
        check_eq("rst_ready",  128'(if128.key_ready), 128'd1);
        check_eq("rst_rk0",    if128.rk_out, 128'd0);
        check_eq("rst_rk_192", if192.rk_out, 128'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // 128-bit key with a foreign key pulsed at cycle 10 of expansion.
        @(negedge clk);
        if128.key_valid = 1'b1;
        if128.key_in    = K128;
        @(posedge clk);
        #1;
        if128.key_valid = 1'b0;
        check_eq("k128_ready_after_accept", 128'(if128.key_ready), 128'd0);
        wait_done(0, 9, cyc);
        check_eq("k128_cycles", 128'(cyc), 128'd40);
        check_eq("k128_ready_done", 128'(if128.key_ready), 128'd1);
        read128(0, v);  check_eq("k128_rk0",  v, K128);
        read128(1, v);  check_eq("k128_rk1",  v, 128'ha0fafe1788542cb123a339392a6c7605);
        read128(2, v);  check_eq("k128_rk2",  v, 128'hf2c295f27a96b9435935807a7359f67f);
        read128(10, v); check_eq("k128_rk10", v, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
        read128(11, v); check_eq("k128_rk11_zero", v, 128'd0);
        repeat (3) @(posedge clk);
        #1;
        check_eq("k128_done_hold", 128'(if128.done), 128'd1);

        // 192-bit key.
        @(negedge clk);
        if192.key_valid = 1'b1;
        if192.key_in    = K192;
        @(posedge clk);
        #1;
        if192.key_valid = 1'b0;
        wait_done(1, -1, cyc);
        check_eq("k192_cycles", 128'(cyc), 128'd46);
        if192.rk_idx = 4'd0;  #1; check_eq("k192_rk0",  if192.rk_out, K192[191:64]);
        if192.rk_idx = 4'd1;  #1; check_eq("k192_rk1",  if192.rk_out, 128'h10111213141516175846f2f95c43f4fe);
        if192.rk_idx = 4'd12; #1; check_eq("k192_rk12", if192.rk_out, 128'ha4970a331a78dc09c418c271e3a41d5d);
        if192.rk_idx = 4'd13; #1; check_eq("k192_rk13_zero", if192.rk_out, 128'd0);

        // 256-bit key.
        @(negedge clk);
        if256.key_valid = 1'b1;
        if256.key_in    = K256;
        @(posedge clk);
        #1;
        if256.key_valid = 1'b0;
        wait_done(2, -1, cyc);
        check_eq("k256_cycles", 128'(cyc), 128'd52);
        if256.rk_idx = 4'd1;  #1; check_eq("k256_rk1",  if256.rk_out, K256[127:0]);
        if256.rk_idx = 4'd2;  #1; check_eq("k256_rk2",  if256.rk_out, 128'ha573c29fa176c498a97fce93a572c09c);
        if256.rk_idx = 4'd14; #1; check_eq("k256_rk14", if256.rk_out, 128'h24fc79ccbf0979e9371ac23c6d68de36);
        if256.rk_idx = 4'd15; #1; check_eq("k256_rk15_zero", if256.rk_out, 128'd0);

        // Re-key from DONE, then reset at cycle 20 of expansion.
        @(negedge clk);
        if128.key_valid = 1'b1;
        if128.key_in    = K128;
        @(posedge clk);
        #1;
        if128.key_valid = 1'b0;
        check_eq("rekey_done_cleared", 128'(if128.done), 128'd0);
        repeat (20) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check_eq("midrst_done",  128'(if128.done), 128'd0);
        check_eq("midrst_ready", 128'(if128.key_ready), 128'd1);
        for (int k = 0; k < 16; k++) begin
            read128(k, v);
            check_eq($sformatf("midrst_rk%0d", k), v, 128'd0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        if128.key_valid = 1'b1;
        if128.key_in    = K128;
        @(posedge clk);
        #1;
        if128.key_valid = 1'b0;
        wait_done(0, -1, cyc);
        check_eq("rekey_cycles", 128'(cyc), 128'd40);
        read128(1, v);  check_eq("rekey_rk1",  v, 128'ha0fafe1788542cb123a339392a6c7605);
        read128(10, v); check_eq("rekey_rk10", v, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

`ifdef AES_KS_ZEROIZE_EN
        @(negedge clk);
        zeroize = 1'b1;
        @(posedge clk);
        #1;
        zeroize = 1'b0;
        check_eq("zeroize_done",  128'(if128.done), 128'd0);
        check_eq("zeroize_ready", 128'(if128.key_ready), 128'd1);
        read128(10, v); check_eq("zeroize_rk10", v, 128'd0);
        read128(0, v);  check_eq("zeroize_rk0",  v, 128'd0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
